// File: rtl/dft_pkg.sv
// Shared widths, counter types and output-register state encoding for the DFT bin accumulator.
package dft_pkg;

  localparam int DFT_DATA_W = 16;
  localparam int DFT_LOG2_N = 3;
  localparam int N_POINTS   = 2 ** DFT_LOG2_N;
  localparam int DFT_ACC_W  = DFT_DATA_W + DFT_LOG2_N;

  typedef struct packed {
    logic signed [DFT_ACC_W-1:0] re;
    logic signed [DFT_ACC_W-1:0] im;
  } cplx_t;

  typedef logic [DFT_LOG2_N-1:0] sample_cnt_t;
  typedef logic [DFT_LOG2_N-1:0] bin_cnt_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/dft_out_reg.sv
// One-entry holding register for a finished bin {re, im, index, last}.
// Latency: loaded value is presented the cycle after load.
// Backpressure: contents held stable while out_valid && !out_ready; caller only loads when empty or draining.
module dft_out_reg
  import dft_pkg::*;
#(
  parameter int ACC_W = DFT_ACC_W,
  parameter int IDX_W = DFT_LOG2_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic signed [ACC_W-1:0] load_re,
  input  logic signed [ACC_W-1:0] load_im,
  input  logic [IDX_W-1:0]        load_index,
  input  logic                    load_last,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] bin_re,
  output logic signed [ACC_W-1:0] bin_im,
  output logic [IDX_W-1:0]        bin_index,
  output logic                    out_last
);

  out_state_t state;
  out_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // A load coinciding with a transfer keeps the register full for back-to-back bins.
  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (load) state_nxt = OUT_FULL;
      OUT_FULL:  if (out_ready && !load) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  assign out_valid = (state == OUT_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_re    <= '0;
      bin_im    <= '0;
      bin_index <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      bin_re    <= load_re;
      bin_im    <= load_im;
      bin_index <= load_index;
      out_last  <= load_last;
    end
  end

endmodule

// File: rtl/dft_bin_accumulator.sv
// Sums N_POINTS rotated samples per bin and emits the complex bin tagged with its index.
// Latency: result valid one cycle after the final sample of a frame is accepted.
// Backpressure: only the final sample of a frame stalls while a previous result is still held.
module dft_bin_accumulator
  import dft_pkg::*;
#(
  parameter int DATA_W    = DFT_DATA_W,
  parameter int LOG2_N    = DFT_LOG2_N,
  parameter int ACC_W     = DATA_W + LOG2_N,
  parameter int SCALE_OUT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  bin_re,
  output logic signed [ACC_W-1:0]  bin_im,
  output logic [LOG2_N-1:0]        bin_index,
  output logic                     out_last
);

  logic [LOG2_N-1:0]       sample_cnt;
  logic [LOG2_N-1:0]       bin_cnt;
  logic signed [ACC_W-1:0] acc_re;
  logic signed [ACC_W-1:0] acc_im;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] y_ext;
  logic signed [ACC_W-1:0] sum_re;
  logic signed [ACC_W-1:0] sum_im;
  logic signed [ACC_W-1:0] res_re;
  logic signed [ACC_W-1:0] res_im;
  logic                    last_sample;
  logic                    stall;
  logic                    accept;
  logic                    final_accept;

  assign last_sample  = &sample_cnt;
  assign stall        = last_sample && out_valid && !out_ready;
  // A frame restart never waits on the consumer, so ready is forced high while it is asserted.
  assign in_ready     = sync_clr || !stall;
  assign accept       = in_valid && in_ready && !sync_clr;
  assign final_accept = accept && last_sample;

  assign x_ext  = {{(ACC_W-DATA_W){x_in[DATA_W-1]}}, x_in};
  assign y_ext  = {{(ACC_W-DATA_W){y_in[DATA_W-1]}}, y_in};
  assign sum_re = acc_re + x_ext;
  assign sum_im = acc_im + y_ext;
  assign res_re = (SCALE_OUT != 0) ? (sum_re >>> LOG2_N) : sum_re;
  assign res_im = (SCALE_OUT != 0) ? (sum_im >>> LOG2_N) : sum_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_re     <= '0;
      acc_im     <= '0;
      sample_cnt <= '0;
      bin_cnt    <= '0;
    end else if (sync_clr) begin
      acc_re     <= '0;
      acc_im     <= '0;
      sample_cnt <= '0;
      bin_cnt    <= '0;
    end else if (accept) begin
      if (last_sample) begin
        acc_re     <= '0;
        acc_im     <= '0;
        sample_cnt <= '0;
        bin_cnt    <= bin_cnt + 1'b1;
      end else begin
        acc_re     <= sum_re;
        acc_im     <= sum_im;
        sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end

  dft_out_reg #(
    .ACC_W (ACC_W),
    .IDX_W (LOG2_N)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (final_accept),
    .load_re    (res_re),
    .load_im    (res_im),
    .load_index (bin_cnt),
    .load_last  (&bin_cnt),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .bin_re     (bin_re),
    .bin_im     (bin_im),
    .bin_index  (bin_index),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_dft_bin_accumulator.sv
// Scoreboard bench: frame-sum reference model feeds an expected queue, a monitor pops on each output transfer.
module tb_dft_bin_accumulator;
  import dft_pkg::*;

  localparam int DW = 16;
  localparam int LN = 3;
  localparam int AW = DW + LN;
  localparam int NP = 1 << LN;

  logic clk = 1'b0;
  logic rst, sync_clr, in_valid, out_ready;
  logic in_ready, in_ready_s, out_valid, out_valid_s, out_last, out_last_s;
  logic signed [DW-1:0] x_in, y_in;
  logic signed [AW-1:0] bin_re, bin_im, bin_re_s, bin_im_s;
  logic [LN-1:0] bin_index, bin_index_s;

  dft_bin_accumulator #(.DATA_W(DW), .LOG2_N(LN), .ACC_W(AW), .SCALE_OUT(0)) dut (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .bin_re(bin_re), .bin_im(bin_im), .bin_index(bin_index), .out_last(out_last));

  dft_bin_accumulator #(.DATA_W(DW), .LOG2_N(LN), .ACC_W(AW), .SCALE_OUT(1)) dut_s (
    .clk(clk), .rst(rst), .sync_clr(sync_clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid_s), .out_ready(out_ready),
    .bin_re(bin_re_s), .bin_im(bin_im_s), .bin_index(bin_index_s), .out_last(out_last_s));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int re;
    int im;
    int idx;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   fr_x[$];
  int   fr_y[$];
  int   bin_k = 0;
  bit   rand_rdy = 1'b0;
  logic rdy_force = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fr_x.delete();
    fr_y.delete();
    bin_k = 0;
  endtask

  task automatic model_clear();
    fr_x.delete();
    fr_y.delete();
    bin_k = 0;
  endtask

  // A frame's bin is the plain integer sum of its samples.
  task automatic model_accept(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
    exp_t e;
    fr_x.push_back(int'(x));
    fr_y.push_back(int'(y));
    if (fr_x.size() == NP) begin
      e.re = 0;
      e.im = 0;
      foreach (fr_x[i]) begin
        e.re += fr_x[i];
        e.im += fr_y[i];
      end
      e.idx = bin_k;
      e.due = cyc + 1;
      exp_q.push_back(e);
      bin_k = (bin_k + 1) % NP;
      fr_x.delete();
      fr_y.delete();
    end
  endtask

  // Monitor: checks first-presentation latency and every transferred result.
  bit   prev_hold = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (out_valid && !prev_hold) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got bin_index %0d expected no output (cycle %0d)", bin_index, cyc);
        end else begin
          chk("latency", cyc, exp_q[0].due);
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("bin_re", bin_re, mon_e.re);
        chk("bin_im", bin_im, mon_e.im);
        chk("bin_index", bin_index, mon_e.idx);
        chk("out_last", out_last, (mon_e.idx == NP - 1) ? 1 : 0);
        chk("scaled_valid", out_valid_s, 1);
        chk("scaled_re", bin_re_s, mon_e.re >>> LN);
        chk("scaled_im", bin_im_s, mon_e.im >>> LN);
        chk("scaled_index", bin_index_s, mon_e.idx);
        chk("scaled_last", out_last_s, (mon_e.idx == NP - 1) ? 1 : 0);
      end
      prev_hold = out_valid && !out_ready;
    end
  end

  task automatic drive(input logic v, input logic signed [DW-1:0] x, input logic signed [DW-1:0] y,
                       input logic clr, output bit acc);
    in_valid  = v;
    x_in      = x;
    y_in      = y;
    sync_clr  = clr;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    @(negedge clk);
    acc = v && in_ready && !clr;
    if (clr) begin
      chk("clr_in_ready", in_ready, 1);
      model_clear();
    end else if (acc) begin
      model_accept(x, y);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sync_clr = 1'b0;
  endtask

  task automatic send(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
    bit a;
    int n = 0;
    do begin
      drive(1'b1, x, y, 1'b0, a);
      n++;
    end while (!a && n < 2000);
    if (!a) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept in %0d cycles expected accept", n);
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, a);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    sync_clr  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bin_re", bin_re, 0);
    chk("rst_bin_im", bin_im, 0);
    chk("rst_bin_index", bin_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready_s", in_ready_s, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    bit a;
    logic signed [DW-1:0] rx, ry;
    rst = 1'b1; sync_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0;

    do_reset();

    // Basic frame, consumer always ready.
    rdy_force = 1'b1;
    for (int i = 0; i < NP; i++) send(16'sh1000, -16'sh0800);
    @(negedge clk);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_bin_re", bin_re, 32'sh0000_8000);
    chk("t2_bin_im", bin_im, -32'sh0000_4000);
    chk("t2_bin_index", bin_index, 0);
    chk("t2_out_last", out_last, 0);
    @(posedge clk);
    #1;

    // Back-pressure: final sample of the next frame must wait for the held result to drain.
    rdy_force = 1'b0;
    for (int i = 0; i < NP; i++) send(16'sh0100, 16'sh0200);
    for (int i = 0; i < NP - 1; i++) send(16'sh0030, -16'sh0040);
    in_valid  = 1'b1;
    x_in      = 16'sh0031;
    y_in      = -16'sh0041;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_in_ready", in_ready, 1);
    model_accept(16'sh0031, -16'sh0041);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Full-scale extremes.
    rdy_force = 1'b1;
    for (int i = 0; i < NP; i++) send(-16'sh8000, 16'sh7FFF);
    @(negedge clk);
    chk("t4_bin_re", bin_re, -32'sh0004_0000);
    chk("t4_bin_im", bin_im, 32'sh0003_FFF8);
    chk("t4_scaled_re", bin_re_s, -32'sh0000_8000);
    chk("t4_scaled_im", bin_im_s, 32'sh0000_7FFF);
    @(posedge clk);
    #1;

    // Frame restart drops its coincident sample and the partial sum.
    for (int i = 0; i < 3; i++) send(16'sh0100, 16'sh0000);
    drive(1'b1, 16'sh7000, 16'sh0000, 1'b1, a);
    for (int i = 0; i < NP; i++) send(16'sh0010, 16'sh0000);
    @(negedge clk);
    chk("t5_bin_re", bin_re, 32'sh0000_0080);
    chk("t5_bin_index", bin_index, 0);
    @(posedge clk);
    #1;

    // Nine frames: index wraps 7 -> 0, last flag on 7 only (checked by monitor).
    drive(1'b0, '0, '0, 1'b1, a);
    for (int f = 0; f < NP + 1; f++)
      for (int i = 0; i < NP; i++) send(DW'($urandom), DW'($urandom));
    idle(2);

    // Reset mid-frame with a result pending discards everything.
    rdy_force = 1'b0;
    for (int i = 0; i < NP + 3; i++) send(16'sh0123, 16'sh0321);
    do_reset();
    rdy_force = 1'b1;
    for (int i = 0; i < NP; i++) send(16'sh0002, -16'sh0003);
    idle(2);

    // Randomised traffic with gaps, random back-pressure and occasional restarts.
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        rx = DW'($urandom);
        ry = DW'($urandom);
        if ($urandom_range(0, 60) == 0) drive(1'b1, rx, ry, 1'b1, a);
        else send(rx, ry);
      end
    end

    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    idle(10);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dft_bin_accumulator.md
Name: dft_bin_accumulator

Overview:
- Sits directly downstream of the CORDIC twiddle-rotation stage in the DFT datapath.
- Consumes one rotated sample (x, y) per accepted cycle and sums N_POINTS consecutive samples into one complex bin value.
- Emits the bin with a valid/ready handshake, tagged with a bin index that counts frames.
- Contains the per-bin sequencing (sample counter, bin counter, output holding register) that the rotation stage does not have.

Parameters:
- DATA_W, 16: width of the signed rotated input samples.
- LOG2_N, 3: log2 of the DFT length; N_POINTS = 2**LOG2_N = 8.
- ACC_W, DATA_W+LOG2_N (19): accumulator and output width. Sized so overflow cannot occur.
- SCALE_OUT, 0: when 1, outputs are the accumulator arithmetically shifted right by LOG2_N (the mean).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- sync_clr, input, 1: synchronous frame restart. Clears the accumulator, the sample counter and the bin counter. Does not clear a pending output.
- in_valid, input, 1: a rotated sample is present.
- in_ready, output, 1: the block accepts the sample this cycle.
- x_in, input, DATA_W: signed real part from the CORDIC stage.
- y_in, input, DATA_W: signed imaginary part from the CORDIC stage.
- out_valid, output, 1: a bin result is held.
- out_ready, input, 1: the consumer takes the result this cycle.
- bin_re, output, ACC_W: signed real sum.
- bin_im, output, ACC_W: signed imaginary sum.
- bin_index, output, LOG2_N: the bin number k of the held result.
- out_last, output, 1: high with out_valid when bin_index == N_POINTS-1.

Behaviour:
- Accept condition: an input is accepted when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Reset values: acc_re, acc_im, sample_cnt, bin_cnt, out_valid, bin_re, bin_im, bin_index and out_last are all 0. in_ready is 1 in the first cycle after reset.
- Input extension: x_in and y_in are sign-extended to ACC_W before addition. There is no saturation; ACC_W guarantees the full-scale range fits.
- Non-final accept (sample_cnt < N_POINTS-1): the sample is added to acc_re/acc_im and sample_cnt increments.
- Final accept (sample_cnt == N_POINTS-1):
  - The output register loads acc + sample (shifted if SCALE_OUT=1).
  - bin_index loads bin_cnt.
  - out_valid is set.
  - acc clears to 0 and sample_cnt clears to 0.
  - bin_cnt increments, wrapping from N_POINTS-1 to 0.
- Latency: out_valid rises on the cycle after the final accept.
- in_ready is 1 except when sample_cnt == N_POINTS-1 && out_valid && !out_ready.
  - Only the final sample of a frame stalls on back-pressure.
  - Accumulation of the next frame continues while a result is pending.
- out_valid clears on a transfer, unless a final accept occurs in the same cycle. In that case the new result loads and out_valid stays 1 (full throughput).
- bin_re, bin_im, bin_index and out_last are stable while out_valid && !out_ready.
- sync_clr has priority over an accept in the same cycle: the sample is dropped and in_ready reads 1. Pending output is unaffected.
- rst mid-frame or with a pending output: all state is discarded to reset values. No partial result is emitted.
- State machine: two implicit states encoded by out_valid.
  - EMPTY (out_valid=0) goes to FULL on a final accept.
  - FULL goes to EMPTY on a transfer without a simultaneous final accept.
  - FULL stays FULL when a transfer and a final accept coincide.

Decomposition:
- Shared package dft_pkg holds:
  - the DATA_W and LOG2_N defaults
  - the N_POINTS constant
  - a typedef for the ACC_W-wide signed complex pair (re, im)
  - the sample and bin counter typedefs
- One natural sub-module: dft_out_reg, the one-entry valid/ready holding register for {re, im, index, last}.
- The accumulator and counters stay in the top module.

Test Plan (N_POINTS=8, DATA_W=16, ACC_W=19):
1. Assert rst for 2 cycles, then release. Required: out_valid=0, bin_re=0, bin_im=0, bin_index=0, in_ready=1.
2. Drive 8 back-to-back samples x=16'sh1000, y=-16'sh0800 with out_ready=1. Required: one cycle after the 8th accept, out_valid=1, bin_re=19'sh08000, bin_im=-19'sh04000, bin_index=0, out_last=0.
3. Hold out_ready=0 with a result pending and send a second frame. Required:
   - 7 samples are accepted.
   - On the 8th, in_ready=0 until out_ready is pulsed.
   - On that cycle the 8th sample is accepted and the new result (bin_index=1) appears the next cycle.
4. Drive 8 samples x=-16'sh8000, y=16'sh7FFF. Required: bin_re=-19'sh40000 and bin_im=19'sh3FFF8, with no wrap. With SCALE_OUT=1: bin_re=-19'sh08000 and bin_im=19'sh07FFF.
5. Accept 3 samples of 16'sh0100, then assert sync_clr in the same cycle as a valid sample of 16'sh7000, then send 8 samples of 16'sh0010. Required: bin_re=19'sh00080, bin_index=0.
6. Send 9 consecutive frames with out_ready=1. Required: bin_index runs 0..7 then 0, and out_last=1 only on bin_index 7.
